keypad_key_filter: RTL and testbench

Parametrised next-generation keypad debouncer. Sits between the keypad scanner and the key decoder/display logic. Accepts one-hot row/column samples of any keypad size and filters press and release edges with independent counts. Produces a held-level output, a packed key code, one-cycle press/release event pulses, and optional auto-repeat.

---
 rtl/keypad_key_filter.sv | 223 ++++++++++++++++++++++
 tb/tb_keypad_key_filter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/keypad_key_filter.sv
// Keypad debouncer: filters one-hot row/column samples into a held key, key code and press/release pulses.
// Optional auto-repeat of press_pulse is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_key_filter #(
   parameter int unsigned ROWS            = 4,
   parameter int unsigned COLS            = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 60000,
   parameter int unsigned RELEASE_CYCLES  = 60000,
   parameter int unsigned REPEAT_DELAY    = 1500000,
   parameter int unsigned REPEAT_PERIOD   = 300000,
   localparam int unsigned CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_pressed,
   input  logic [ROWS-1:0]   row_idx,
   input  logic [COLS-1:0]   col_idx,
   output logic              key_valid,
   output logic [ROWS-1:0]   key_row,
   output logic [COLS-1:0]   key_col,
   output logic [CODE_W-1:0] key_code,
   output logic              press_pulse,
   output logic              release_pulse
);

   localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [CW-1:0]     cnt_r, cnt_s;
   logic [ROWS-1:0]   lat_row_r, lat_row_s;
   logic [COLS-1:0]   lat_col_r, lat_col_s;
   logic              valid_d_s;
   logic [ROWS-1:0]   row_d_s;
   logic [COLS-1:0]   col_d_s;
   logic [CODE_W-1:0] code_d_s;
   logic              press_d_s, release_d_s, accept_s, rep_pulse_s;
   logic              sample_ok_s, match_s;

   function automatic logic [CODE_W-1:0] code_of(input logic [ROWS-1:0] r, input logic [COLS-1:0] c);
      int rp;
      int cp;
      rp = 0;
      cp = 0;
      for (int i = 0; i < int'(ROWS); i++) if (r[i]) rp = i;
      for (int j = 0; j < int'(COLS); j++) if (c[j]) cp = j;
      return CODE_W'(rp * int'(COLS) + cp);
   endfunction

   assign sample_ok_s = key_pressed && $onehot(row_idx) && $onehot(col_idx);
   assign match_s     = sample_ok_s && (row_idx == lat_row_r) && (col_idx == lat_col_r);

   // Debounce state machine: next state, shared counter, latch and next output values.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      lat_row_s   = lat_row_r;
      lat_col_s   = lat_col_r;
      valid_d_s   = key_valid;
      row_d_s     = key_row;
      col_d_s     = key_col;
      code_d_s    = key_code;
      press_d_s   = 1'b0;
      release_d_s = 1'b0;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (sample_ok_s) begin
               lat_row_s = row_idx;
               lat_col_s = col_idx;
               cnt_s     = '0;
               state_s   = PRESS_WAIT;
            end else begin
               state_s = IDLE;
            end
         end
         PRESS_WAIT: begin
            if (match_s) begin
               if (cnt_r == DEB_LAST) begin
                  state_s   = HELD;
                  cnt_s     = '0;
                  valid_d_s = 1'b1;
                  row_d_s   = lat_row_r;
                  col_d_s   = lat_col_r;
                  code_d_s  = code_of(lat_row_r, lat_col_r);
                  press_d_s = 1'b1;
                  accept_s  = 1'b1;
               end else begin
                  cnt_s = cnt_r + CW'(1);
               end
            end else if (sample_ok_s) begin
               lat_row_s = row_idx;
               lat_col_s = col_idx;
               cnt_s     = '0;
            end else begin
               state_s   = IDLE;
               cnt_s     = '0;
               lat_row_s = '0;
               lat_col_s = '0;
            end
         end
         HELD: begin
            cnt_s = '0;
            if (match_s) begin
               state_s = HELD;
            end else begin
               state_s = RELEASE_WAIT;
            end
         end
         RELEASE_WAIT: begin
            if (match_s) begin
               state_s = HELD;
               cnt_s   = '0;
            end else if (cnt_r == REL_LAST) begin
               state_s     = IDLE;
               cnt_s       = '0;
               lat_row_s   = '0;
               lat_col_s   = '0;
               valid_d_s   = 1'b0;
               row_d_s     = '0;
               col_d_s     = '0;
               code_d_s    = '0;
               release_d_s = 1'b1;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_s   = IDLE;
            cnt_s     = '0;
            lat_row_s = '0;
            lat_col_s = '0;
            valid_d_s = 1'b0;
            row_d_s   = '0;
            col_d_s   = '0;
            code_d_s  = '0;
         end
      endcase
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_cnt_r, rep_cnt_s;
   logic          rep_periodic_r, rep_periodic_s;

   // Repeat timer: initial delay after accept, then fixed period; pauses while a release is pending.
   always_comb begin
      rep_cnt_s      = rep_cnt_r;
      rep_periodic_s = rep_periodic_r;
      rep_pulse_s    = 1'b0;
      if (accept_s || release_d_s) begin
         rep_cnt_s      = '0;
         rep_periodic_s = 1'b0;
      end else if (state_r == HELD && match_s) begin
         if (rep_cnt_r == (rep_periodic_r ? RP_LAST : RD_LAST)) begin
            rep_pulse_s    = 1'b1;
            rep_cnt_s      = '0;
            rep_periodic_s = 1'b1;
         end else begin
            rep_cnt_s = rep_cnt_r + RW'(1);
         end
      end else begin
         rep_cnt_s = rep_cnt_r;
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_r      <= '0;
         rep_periodic_r <= 1'b0;
      end else begin
         rep_cnt_r      <= rep_cnt_s;
         rep_periodic_r <= rep_periodic_s;
      end
   end
`else
   // Repeat timing has no effect in this build.
   logic unused_repeat_cfg_s;
   assign unused_repeat_cfg_s = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
   assign rep_pulse_s = 1'b0;
`endif

   // State, counter, latch and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         lat_row_r     <= '0;
         lat_col_r     <= '0;
         key_valid     <= 1'b0;
         key_row       <= '0;
         key_col       <= '0;
         key_code      <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         lat_row_r     <= lat_row_s;
         lat_col_r     <= lat_col_s;
         key_valid     <= valid_d_s;
         key_row       <= row_d_s;
         key_col       <= col_d_s;
         key_code      <= code_d_s;
         press_pulse   <= press_d_s | rep_pulse_s;
         release_pulse <= release_d_s;
      end
   end

endmodule

// File: tb/tb_keypad_key_filter.sv
// Directed bench for keypad_key_filter: 4x4, debounce 4, release 3, repeat delay 8 / period 4.
module tb_keypad_key_filter;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_pressed;
   logic [3:0] row_idx;
   logic [3:0] col_idx;
   logic       key_valid;
   logic [3:0] key_row;
   logic [3:0] key_col;
   logic [3:0] key_code;
   logic       press_pulse;
   logic       release_pulse;

   int total = 0;
   int bad   = 0;
   int pulses;

   keypad_key_filter #(
      .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(3),
      .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
   ) dut (
      .clk(clk), .rst(rst), .key_pressed(key_pressed), .row_idx(row_idx), .col_idx(col_idx),
      .key_valid(key_valid), .key_row(key_row), .key_col(key_col), .key_code(key_code),
      .press_pulse(press_pulse), .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [3:0] er, input logic [3:0] ec,
                          input logic [3:0] ecode, input logic epp, input logic erp);
      chk({tag, ".valid"}, 32'(key_valid), 32'(ev));
      chk({tag, ".row"}, 32'(key_row), 32'(er));
      chk({tag, ".col"}, 32'(key_col), 32'(ec));
      chk({tag, ".code"}, 32'(key_code), 32'(ecode));
      chk({tag, ".press"}, 32'(press_pulse), 32'(epp));
      chk({tag, ".release"}, 32'(release_pulse), 32'(erp));
   endtask

   task automatic step(input logic kp, input logic [3:0] r, input logic [3:0] c);
      key_pressed = kp;
      row_idx     = r;
      col_idx     = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      key_pressed = 1'b0;
      row_idx = 4'b0000;
      col_idx = 4'b0000;
      step(1'b0, 4'b0000, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000);
      chk_out("reset", 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Basic press: accept on the 5th sampling edge, code = 0*4+1.
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 4'b0001, 4'b0010);
         chk_out("t1.wait", 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
      end
      step(1'b1, 4'b0001, 4'b0010);
      chk_out("t1.accept", 1'b1, 4'b0001, 4'b0010, 4'd1, 1'b1, 1'b0);
      step(1'b1, 4'b0001, 4'b0010);
      chk_out("t1.after", 1'b1, 4'b0001, 4'b0010, 4'd1, 1'b0, 1'b0);

      // Short dropout is filtered.
      step(1'b0, 4'b0001, 4'b0010);
      chk("t3.drop1.valid", 32'(key_valid), 32'd1);
      step(1'b0, 4'b0001, 4'b0010);
      chk("t3.drop2.valid", 32'(key_valid), 32'd1);
      step(1'b1, 4'b0001, 4'b0010);
      chk("t3.back.valid", 32'(key_valid), 32'd1);
      chk("t3.back.release", 32'(release_pulse), 32'd0);
      step(1'b1, 4'b0001, 4'b0010);

      // Full release: HELD exit edge plus 3 counted absent edges.
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 4'b0000, 4'b0000);
         chk("t3.rel.valid", 32'(key_valid), 32'd1);
         chk("t3.rel.release", 32'(release_pulse), 32'd0);
         chk("t3.rel.code", 32'(key_code), 32'd1);
      end
      step(1'b0, 4'b0000, 4'b0000);
      chk_out("t3.release", 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b1);
      step(1'b0, 4'b0000, 4'b0000);
      chk_out("t3.idle", 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);

      // Gap during debounce restarts the press.
      for (int i = 1; i <= 3; i++) step(1'b1, 4'b0001, 4'b0010);
      step(1'b0, 4'b0000, 4'b0000);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 4'b0001, 4'b0010);
         chk("t2.wait.valid", 32'(key_valid), 32'd0);
         chk("t2.wait.press", 32'(press_pulse), 32'd0);
      end
      step(1'b1, 4'b0001, 4'b0010);
      chk_out("t2.accept", 1'b1, 4'b0001, 4'b0010, 4'd1, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) step(1'b0, 4'b0000, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000);
      chk("t2.release", 32'(release_pulse), 32'd1);

      // Multi-hot column and zero row never count as a key.
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 4'b0001, 4'b0110);
         pulses += int'(key_valid) + int'(press_pulse) + int'(release_pulse);
      end
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 4'b0000, 4'b0010);
         pulses += int'(key_valid) + int'(press_pulse) + int'(release_pulse);
      end
      chk("t4.invalid.activity", 32'(pulses), 32'd0);

      // Key change mid-debounce relatches; code = 2*4+1.
      step(1'b1, 4'b0001, 4'b0010);
      step(1'b1, 4'b0001, 4'b0010);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 4'b0100, 4'b0010);
         chk("t4.switch.valid", 32'(key_valid), 32'd0);
      end
      step(1'b1, 4'b0100, 4'b0010);
      chk_out("t4.accept", 1'b1, 4'b0100, 4'b0010, 4'd9, 1'b1, 1'b0);
      step(1'b1, 4'b0100, 4'b0010);

      // Reset while held clears everything without a release pulse.
      rst = 1'b1;
      step(1'b1, 4'b0100, 4'b0010);
      chk_out("t5.reset", 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 4'b0100, 4'b0010);
         chk("t5.wait.valid", 32'(key_valid), 32'd0);
      end
      step(1'b1, 4'b0100, 4'b0010);
      chk_out("t5.reaccept", 1'b1, 4'b0100, 4'b0010, 4'd9, 1'b1, 1'b0);

      // Hold 30 more cycles: repeats at +8, +12, ... only with auto-repeat.
      pulses = 0;
      for (int k = 1; k <= 30; k++) begin
         step(1'b1, 4'b0100, 4'b0010);
`ifdef KEYPAD_AUTOREPEAT_EN
         chk("t6.repeat", 32'(press_pulse),
             32'((k == 8) || (k == 12) || (k == 16) || (k == 20) || (k == 24) || (k == 28)));
`else
         pulses += int'(press_pulse);
`endif
      end
`ifndef KEYPAD_AUTOREPEAT_EN
      chk("t6.no_repeat", 32'(pulses), 32'd0);
`endif
      chk("t6.valid", 32'(key_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
